// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes and ALU select codes.
// Also consumed by the ALU control block.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StHalt   = 3'd7
    } ctrl_state_e;

    localparam logic [6:0] OpcodeR   = 7'b0110011;
    localparam logic [6:0] OpcodeI   = 7'b0010011;
    localparam logic [6:0] OpcodeLw  = 7'b0000011;
    localparam logic [6:0] OpcodeSw  = 7'b0100011;
    localparam logic [6:0] OpcodeBeq = 7'b1100011;

    localparam logic [1:0] AluBRs2  = 2'b00;
    localparam logic [1:0] AluBFour = 2'b01;
    localparam logic [1:0] AluBImm  = 2'b10;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    function automatic logic opcode_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OpcodeR, OpcodeI, OpcodeLw, OpcodeSw, OpcodeBeq: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts cycles a memory request waits unacknowledged and flags the cycle the limit is reached.
// hit is combinational so the controller can abandon the request on that same edge.
module mem_timeout_cnt #(
    parameter int unsigned TO_W        = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clear,
    output logic hit
);

    localparam logic [TO_W-1:0] LastWait = TO_W'(MEM_TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // inc already excludes mem_ready, so an acknowledge on the limit cycle never hits
    assign hit = inc && (cnt_q == LastWait);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the shared datapath and memory.
// Strobes are decoded from state plus opcode/zero/mem_ready; counters and error flags are registered.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [CNT_W-1:0] retired,
    output logic             err_illegal,
    output logic             err_timeout,
    output logic [2:0]       state_o
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    logic             err_illegal_q, err_timeout_q;
    logic             retire, set_illegal;
    logic             to_inc, to_clear, to_hit;

    assign to_inc   = mem_req && !mem_ready;
    assign to_clear = mem_ready || (state_d != state_q);

    mem_timeout_cnt #(
        .TO_W        (TO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_timeout_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (to_inc),
        .clear (to_clear),
        .hit   (to_hit)
    );

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            StFetch: begin
                if (to_hit) begin
                    state_d = StHalt;
                end else if (run && mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode_supported(opcode)) begin
                    state_d = StExec;
                end else begin
                    state_d     = StHalt;
                    set_illegal = 1'b1;
                end
            end
            StExec: begin
                case (opcode)
                    OpcodeR, OpcodeI:   state_d = StWb;
                    OpcodeLw, OpcodeSw: state_d = StMem;
                    OpcodeBeq: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    // Opcode changed under a held IR: treat as illegal rather than guess
                    default: begin
                        state_d     = StHalt;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            StMem: begin
                if (to_hit) begin
                    state_d = StHalt;
                end else if (mem_ready) begin
                    if (opcode == OpcodeLw) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StHalt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StFetch;
            retired_q     <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (set_illegal) begin
                err_illegal_q <= 1'b1;
            end
            if (to_hit) begin
                err_timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = AluBRs2;
        alu_op     = AluOpAdd;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            StFetch: begin
                if (run) begin
                    mem_req   = 1'b1;
                    alu_src_b = AluBFour;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
            end
            StDecode: begin
                alu_src_b = AluBImm;
            end
            StExec: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OpcodeR: begin
                        alu_src_b = AluBRs2;
                        alu_op    = AluOpFunct;
                    end
                    OpcodeI: begin
                        alu_src_b = AluBImm;
                        alu_op    = AluOpFunct;
                    end
                    OpcodeLw, OpcodeSw: begin
                        alu_src_b = AluBImm;
                    end
                    OpcodeBeq: begin
                        alu_op   = AluOpSub;
                        pc_src   = 1'b1;
                        pc_write = zero;
                    end
                    default: alu_src_a = 1'b0;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                mem_we  = (opcode == OpcodeSw);
            end
            StWb: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OpcodeLw);
            end
            default: ;
        endcase
    end

    assign retired     = retired_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected strobe vectors go through a scoreboard
// queue and are compared at mid-cycle; retired count and error flags are checked at instruction ends.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W       = 32;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned TO_W        = 4;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpLw  = 7'b0000011;
    localparam logic [6:0] OpSw  = 7'b0100011;
    localparam logic [6:0] OpBeq = 7'b1100011;
    localparam logic [6:0] OpBad = 7'b1111111;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             run = 1'b0;
    logic [6:0]       opcode = 7'b0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]       alu_src_b, alu_op;
    logic             reg_write, mem_to_reg, err_illegal, err_timeout;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .i_or_d      (i_or_d),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .retired     (retired),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .state_o     (state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
    } out_t;

    out_t             exp_q[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [CNT_W-1:0] exp_ret = '0;

    function automatic out_t o_fetch(input bit r, input bit rdy);
        out_t o = '0;
        o.st = 3'd0;
        if (r) begin
            o.mem_req   = 1'b1;
            o.alu_src_b = 2'b01;
            o.ir_write  = rdy;
            o.pc_write  = rdy;
        end
        return o;
    endfunction

    function automatic out_t o_decode();
        out_t o = '0;
        o.st        = 3'd1;
        o.alu_src_b = 2'b10;
        return o;
    endfunction

    function automatic out_t o_exec(input logic [6:0] op, input bit z);
        out_t o = '0;
        o.st        = 3'd2;
        o.alu_src_a = 1'b1;
        if (op == OpR) begin
            o.alu_src_b = 2'b00; o.alu_op = 2'b10;
        end else if (op == OpI) begin
            o.alu_src_b = 2'b10; o.alu_op = 2'b10;
        end else if (op == OpLw || op == OpSw) begin
            o.alu_src_b = 2'b10; o.alu_op = 2'b00;
        end else begin
            o.alu_src_b = 2'b00; o.alu_op = 2'b01; o.pc_src = 1'b1; o.pc_write = z;
        end
        return o;
    endfunction

    function automatic out_t o_mem(input logic [6:0] op);
        out_t o = '0;
        o.st      = 3'd3;
        o.mem_req = 1'b1;
        o.i_or_d  = 1'b1;
        o.mem_we  = (op == OpSw);
        return o;
    endfunction

    function automatic out_t o_wb(input logic [6:0] op);
        out_t o = '0;
        o.st         = 3'd4;
        o.reg_write  = 1'b1;
        o.mem_to_reg = (op == OpLw);
        return o;
    endfunction

    function automatic out_t o_halt();
        out_t o = '0;
        o.st = 3'd7;
        return o;
    endfunction

    task automatic step(input bit rst_n, input bit r, input logic [6:0] op, input bit z,
                        input bit rdy, input out_t e, input string tag);
        out_t got, want;
        @(negedge clk);
        reset     = rst_n;
        run       = r;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        #1;
        got = {state_o, mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src, alu_src_a,
               alu_src_b, alu_op, reg_write, mem_to_reg};
        want = exp_q.pop_front();
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic chk(input string tag, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] e);
        n_cmp++;
        assert (act === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, e);
        end
    endtask

    // One full instruction, with `waits` unacknowledged cycles in MEM, then an idle FETCH cycle
    task automatic instr(input logic [6:0] op, input bit z, input int waits, input string tag);
        step(1, 1, op, z, 1, o_fetch(1, 1), {tag, "_fetch"});
        step(1, 1, op, z, 1, o_decode(), {tag, "_decode"});
        step(1, 1, op, z, 1, o_exec(op, z), {tag, "_exec"});
        if (op == OpLw || op == OpSw) begin
            for (int i = 0; i < waits; i++) step(1, 1, op, z, 0, o_mem(op), {tag, "_memwait"});
            step(1, 1, op, z, 1, o_mem(op), {tag, "_mem"});
        end
        if (op == OpR || op == OpI || op == OpLw) step(1, 1, op, z, 1, o_wb(op), {tag, "_wb"});
        exp_ret++;
        step(1, 0, op, z, 0, o_fetch(0, 0), {tag, "_idle"});
        chk({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic do_reset(input out_t first, input string tag);
        step(0, 0, OpR, 0, 0, first, {tag, "_rst0"});
        step(0, 0, OpR, 0, 0, o_fetch(0, 0), {tag, "_rst1"});
        exp_ret = '0;
        chk({tag, "_retired"}, retired, exp_ret);
        chk({tag, "_err_illegal"}, {31'b0, err_illegal}, 32'd0);
        chk({tag, "_err_timeout"}, {31'b0, err_timeout}, 32'd0);
    endtask

    initial begin
        do_reset(o_fetch(0, 0), "por");

        instr(OpR, 0, 0, "r_add");
        instr(OpI, 0, 0, "i_addi");
        instr(OpLw, 0, 3, "lw_wait3");
        instr(OpSw, 0, 1, "sw_wait1");
        instr(OpBeq, 1, 0, "beq_taken");
        instr(OpBeq, 0, 0, "beq_not");
        instr(OpLw, 0, 0, "lw_fast");

        // Reset in the middle of a data access abandons it
        step(1, 1, OpLw, 0, 1, o_fetch(1, 1), "abort_fetch");
        step(1, 1, OpLw, 0, 1, o_decode(), "abort_decode");
        step(1, 1, OpLw, 0, 1, o_exec(OpLw, 0), "abort_exec");
        step(1, 1, OpLw, 0, 0, o_mem(OpLw), "abort_mem");
        do_reset(o_mem(OpLw), "abort");

        // Illegal opcode halts with no further requests
        step(1, 1, OpBad, 0, 1, o_fetch(1, 1), "ill_fetch");
        step(1, 1, OpBad, 0, 1, o_decode(), "ill_decode");
        for (int i = 0; i < 3; i++) step(1, 1, OpBad, 0, 1, o_halt(), "ill_halt");
        chk("ill_flag", {31'b0, err_illegal}, 32'd1);
        chk("ill_retired", retired, exp_ret);
        do_reset(o_halt(), "ill");

        // FETCH unacknowledged for the full limit times out
        for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 1, OpR, 0, 0, o_fetch(1, 0), "to_wait");
        step(1, 1, OpR, 0, 0, o_halt(), "to_halt");
        chk("to_flag", {31'b0, err_timeout}, 32'd1);
        do_reset(o_halt(), "to");

        // Acknowledge arriving on the limit cycle wins
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) step(1, 1, OpR, 0, 0, o_fetch(1, 0), "edge_wait");
        step(1, 1, OpR, 0, 1, o_fetch(1, 1), "edge_ack");
        step(1, 1, OpR, 0, 1, o_decode(), "edge_decode");
        chk("edge_no_err", {31'b0, err_timeout}, 32'd0);
        step(1, 1, OpR, 0, 1, o_exec(OpR, 0), "edge_exec");
        step(1, 1, OpR, 0, 1, o_wb(OpR), "edge_wb");
        exp_ret++;
        step(1, 0, OpR, 0, 0, o_fetch(0, 0), "edge_idle");
        chk("edge_retired", retired, exp_ret);

        // Data access timeout in MEM
        step(1, 1, OpSw, 0, 1, o_fetch(1, 1), "memto_fetch");
        step(1, 1, OpSw, 0, 1, o_decode(), "memto_decode");
        step(1, 1, OpSw, 0, 1, o_exec(OpSw, 0), "memto_exec");
        for (int i = 0; i < MEM_TIMEOUT; i++) step(1, 1, OpSw, 0, 0, o_mem(OpSw), "memto_wait");
        step(1, 1, OpSw, 0, 1, o_halt(), "memto_halt");
        chk("memto_flag", {31'b0, err_timeout}, 32'd1);
        chk("memto_retired", retired, exp_ret);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
